xor_parity_acc: RTL

- Streaming, parametrised XOR accumulator. It folds a frame of WIDTH-bit words into a running XOR word and a single parity bit.
- Successor to the 2-input xor primitive block: the same gate-level XOR datapath, generalised to WIDTH bits, with a frame counter, valid/ready handshakes and a result-hold state.
- Sits between a data source and a checker that needs a per-frame parity or XOR signature.

---
 rtl/xor_parity_acc.sv | 125 ++++++++++++
 1 files changed

// File: rtl/xor_parity_acc.sv
// Streaming XOR/parity accumulator over valid/ready framed words.
// Build with XOR_ODD_PARITY_EN defined for odd parity on out_bit.
module xor_parity_acc #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_bit,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             ovf_q;
    logic [WIDTH-1:0] par_c;
    logic             par_bit;
    logic             beat_ok;
    logic             at_limit;

    assign beat_ok  = in_valid && in_ready_q;
    assign cnt_d    = cnt_q + CW'(1);
    assign at_limit = (cnt_d == CW'(MAX_LEN));

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_xor
            xor u_x (acc_d[i], acc_q[i], in_data[i]);
        end
        assign par_c[0] = acc_q[0];
        for (i = 1; i < WIDTH; i++) begin : g_red
            xor u_r (par_c[i], par_c[i-1], acc_q[i]);
        end
    endgenerate

`ifdef XOR_ODD_PARITY_EN
    not u_inv (par_bit, par_c[WIDTH-1]);
`else
    assign par_bit = par_c[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (beat_ok) begin
                        acc_q <= in_data;
                        cnt_q <= CW'(1);
                        if (in_last || MAX_LEN == 1) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            ovf_q       <= !in_last;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat_ok) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (in_last || at_limit) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            ovf_q       <= !in_last;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result fields are masked so they read zero outside the hold state.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = acc_q & {WIDTH{out_valid_q}};
    assign out_bit   = par_bit & out_valid_q;
    assign out_count = cnt_q & {CW{out_valid_q}};
    assign out_ovf   = ovf_q;

endmodule
